// File: rtl/fir_src_pkg.sv
// fir_src_pkg: shared types, constants and dither helpers for the tone source.
// The LFSR/saturation helpers are only referenced when FIR_SRC_DITHER_EN is defined.
package fir_src_pkg;
  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    STOPPING,
    DONE
  } state_t;

  localparam int ROM_AW = 8;
  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W-1:0] AMP_MAX = 16'sd32767;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // x^16+x^14+x^13+x^11+1, Fibonacci form shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat_add(
    input logic signed [SAMPLE_W-1:0] a,
    input logic [1:0] d
  );
    logic signed [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {{(SAMPLE_W-1){d[1]}}, d};
    if (s > 17'sd32767) return AMP_MAX;
    if (s < -17'sd32768) return -AMP_MAX - 16'sd1;
    return s[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/fir_src_sine_rom.sv
// fir_src_sine_rom: combinational 256-entry full-wave sine lookup, 32767 peak.
// Stored as a 65-entry quarter wave and unfolded by symmetry.
module fir_src_sine_rom
  import fir_src_pkg::*;
(
  input  logic [ROM_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] sample
);
  logic [6:0] idx;
  logic signed [SAMPLE_W-1:0] mag;

  always_comb begin
    idx = addr[6:0];
    // second quarter mirrors the first: 128-k taken mod 128
    if (addr[6:0] > 7'd64) idx = 7'd0 - addr[6:0];
    mag = '0;
    unique case (idx)
      7'd0:  mag = 16'sd0;
      7'd1:  mag = 16'sd804;
      7'd2:  mag = 16'sd1608;
      7'd3:  mag = 16'sd2410;
      7'd4:  mag = 16'sd3212;
      7'd5:  mag = 16'sd4011;
      7'd6:  mag = 16'sd4808;
      7'd7:  mag = 16'sd5602;
      7'd8:  mag = 16'sd6393;
      7'd9:  mag = 16'sd7179;
      7'd10: mag = 16'sd7962;
      7'd11: mag = 16'sd8739;
      7'd12: mag = 16'sd9512;
      7'd13: mag = 16'sd10278;
      7'd14: mag = 16'sd11039;
      7'd15: mag = 16'sd11793;
      7'd16: mag = 16'sd12539;
      7'd17: mag = 16'sd13279;
      7'd18: mag = 16'sd14010;
      7'd19: mag = 16'sd14732;
      7'd20: mag = 16'sd15446;
      7'd21: mag = 16'sd16151;
      7'd22: mag = 16'sd16846;
      7'd23: mag = 16'sd17530;
      7'd24: mag = 16'sd18204;
      7'd25: mag = 16'sd18868;
      7'd26: mag = 16'sd19519;
      7'd27: mag = 16'sd20159;
      7'd28: mag = 16'sd20787;
      7'd29: mag = 16'sd21403;
      7'd30: mag = 16'sd22005;
      7'd31: mag = 16'sd22594;
      7'd32: mag = 16'sd23170;
      7'd33: mag = 16'sd23731;
      7'd34: mag = 16'sd24279;
      7'd35: mag = 16'sd24811;
      7'd36: mag = 16'sd25329;
      7'd37: mag = 16'sd25832;
      7'd38: mag = 16'sd26319;
      7'd39: mag = 16'sd26790;
      7'd40: mag = 16'sd27245;
      7'd41: mag = 16'sd27683;
      7'd42: mag = 16'sd28105;
      7'd43: mag = 16'sd28510;
      7'd44: mag = 16'sd28898;
      7'd45: mag = 16'sd29268;
      7'd46: mag = 16'sd29621;
      7'd47: mag = 16'sd29956;
      7'd48: mag = 16'sd30273;
      7'd49: mag = 16'sd30571;
      7'd50: mag = 16'sd30852;
      7'd51: mag = 16'sd31113;
      7'd52: mag = 16'sd31356;
      7'd53: mag = 16'sd31580;
      7'd54: mag = 16'sd31785;
      7'd55: mag = 16'sd31971;
      7'd56: mag = 16'sd32137;
      7'd57: mag = 16'sd32285;
      7'd58: mag = 16'sd32412;
      7'd59: mag = 16'sd32521;
      7'd60: mag = 16'sd32609;
      7'd61: mag = 16'sd32678;
      7'd62: mag = 16'sd32728;
      7'd63: mag = 16'sd32757;
      7'd64: mag = 16'sd32767;
      default: mag = '0;
    endcase
    sample = addr[7] ? -mag : mag;
  end
endmodule

// File: rtl/fir_tone_source.sv
// fir_tone_source: framed DDS sine AXI-Stream master feeding the FIR slave port.
// Define FIR_SRC_DITHER_EN to add 2-bit LFSR dither with saturation.
module fir_tone_source
  import fir_src_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int PHASE_W   = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PHASE_W-1:0]         cfg_phase_inc,
  input  logic [15:0]                cfg_num_frames,
  input  logic [1:0]                 cfg_shift,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  output logic signed [SAMPLE_W-1:0] m_axis_tdata,
  output logic [3:0]                 m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic                       done
);
  localparam int BW = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  state_t state;
  logic [PHASE_W-1:0] phase, inc_q, phase_nx;
  logic [15:0] nframes_q, frame_cnt;
  logic [1:0] shift_q, shift_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic signed [SAMPLE_W-1:0] rom_val, base, sample_nx;
  logic idle, hs, last_beat, final_frame;

  assign m_axis_tkeep = 4'hF;
  assign idle = state == IDLE;
  assign hs = m_axis_tvalid && m_axis_tready;
  assign last_beat = beat_cnt == LAST_BEAT;
  // a stop arriving with the tlast handshake closes that same frame
  assign final_frame = (state == STOPPING) || cfg_stop ||
    (nframes_q != 16'd0 && frame_cnt == nframes_q - 16'd1);

  assign phase_nx = idle ? '0 : phase + inc_q;
  assign shift_nx = idle ? cfg_shift : shift_q;
  assign beat_nx = last_beat ? '0 : beat_cnt + BW'(1);

  fir_src_sine_rom u_rom (
    .addr  (phase_nx[PHASE_W-1 -: ROM_AW]),
    .sample(rom_val)
  );

  assign base = rom_val >>> shift_nx;

`ifdef FIR_SRC_DITHER_EN
  logic [15:0] lfsr, lfsr_nx;
  assign lfsr_nx = idle ? LFSR_SEED : lfsr_step(lfsr);
  assign sample_nx = sat_add(base, lfsr_nx[1:0]);

  always_ff @(posedge clk) begin
    if (!reset) lfsr <= LFSR_SEED;
    else if ((idle && cfg_start) || hs) lfsr <= lfsr_nx;
  end
`else
  assign sample_nx = base;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      inc_q         <= '0;
      nframes_q     <= '0;
      shift_q       <= '0;
      beat_cnt      <= '0;
      frame_cnt     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            inc_q         <= cfg_phase_inc;
            nframes_q     <= cfg_num_frames;
            shift_q       <= cfg_shift;
            phase         <= '0;
            beat_cnt      <= '0;
            frame_cnt     <= '0;
            m_axis_tdata  <= sample_nx;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            busy          <= 1'b1;
            state         <= STREAM;
          end
        end
        STREAM, STOPPING: begin
          if (state == STREAM && cfg_stop) state <= STOPPING;
          if (hs) begin
            if (last_beat && final_frame) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= DONE;
            end else begin
              phase        <= phase_nx;
              beat_cnt     <= beat_nx;
              m_axis_tdata <= sample_nx;
              m_axis_tlast <= beat_nx == LAST_BEAT;
              if (last_beat) frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tone_source.sv
// tb_fir_tone_source: scoreboard bench for the framed sine source.
// Expected beats come from a $sin reference plus hand-computed anchor values.
module tb_fir_tone_source;
  typedef struct {
    int d;
    bit l;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [23:0] cfg_phase_inc = '0;
  logic [15:0] cfg_num_frames = '0;
  logic [1:0] cfg_shift = '0;
  logic cfg_start = 1'b0;
  logic cfg_stop = 1'b0;
  logic m_axis_tready = 1'b1;
  logic signed [15:0] m_axis_tdata;
  logic [3:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tvalid, busy, done;

  int applied = 0;
  int miscompares = 0;
  int beats_seen = 0;
  int chk_done = 0;
  bit expect_done = 1'b0;
  int hand[int];
  exp_t q[$];

  fir_tone_source dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_num_frames(cfg_num_frames),
    .cfg_shift     (cfg_shift),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic int rom_m(int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic chk(string nm, int act, int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_s(string nm, int act, int exp);
`ifdef FIR_SRC_DITHER_EN
    applied++;
    if (act - exp < -2 || act - exp > 1) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (-2..+1)", nm, act, exp);
    end
`else
    chk(nm, act, exp);
`endif
  endtask

  task automatic push_run(int n, logic [23:0] inc, int sh);
    logic [23:0] ph;
    ph = '0;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = rom_m(int'(ph[23:16])) >>> sh;
      e.l = (i % 256) == 255;
      e.idx = i;
      q.push_back(e);
      ph = ph + inc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(logic [23:0] inc, logic [15:0] nf,
                           logic [1:0] sh, logic stop_too);
    cfg_phase_inc = inc;
    cfg_num_frames = nf;
    cfg_shift = sh;
    cfg_start = 1'b1;
    cfg_stop = stop_too;
    tick();
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    chk("start_valid", m_axis_tvalid, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_beats(int n);
    for (int c = 0; c < 20000 && beats_seen < n; c++) tick();
    chk($sformatf("reach_beat%0d", n), beats_seen, n);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20000; c++) begin
      if (q.size() == 0 && chk_done == 0 && !busy && !done) break;
      tick();
    end
    chk("drain", q.size(), 0);
    chk("idle_busy", busy, 0);
    repeat (4) tick();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tkeep"}, m_axis_tkeep, 15);
  endtask

  task automatic new_test(bit want_done);
    q.delete();
    hand.delete();
    beats_seen = 0;
    chk_done = 0;
    expect_done = want_done;
  endtask

  // monitor: pops the scoreboard on every accepted beat
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (chk_done == 2) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_tvalid", m_axis_tvalid, 0);
        chk_done = 1;
      end else if (chk_done == 1) begin
        chk("done_clear", done, 0);
        chk_done = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", int'(m_axis_tvalid), 0);
        end else begin
          e = q.pop_front();
          chk_s($sformatf("beat%0d_data", e.idx), m_axis_tdata, e.d);
          chk($sformatf("beat%0d_last", e.idx), m_axis_tlast, int'(e.l));
          if (hand.exists(e.idx))
            chk_s($sformatf("anchor%0d", e.idx), m_axis_tdata, hand[e.idx]);
          beats_seen++;
          if (q.size() == 0 && expect_done) chk_done = 2;
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // one frame, 5-cycle stall while beat 10 is presented
    new_test(1'b1);
    hand[0] = 0;
    hand[1] = 804;
    hand[2] = 1608;
    hand[10] = 7962;
    hand[11] = 8739;
    hand[64] = 32767;
    hand[128] = 0;
    hand[192] = -32767;
    push_run(256, 24'h010000, 0);
    start_run(24'h010000, 16'd1, 2'd0, 1'b0);
    wait_beats(10);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_tdata", m_axis_tdata, 7962);
      chk("stall_tlast", m_axis_tlast, 0);
      chk("stall_tvalid", m_axis_tvalid, 1);
      tick();
    end
    m_axis_tready = 1'b1;
    wait_idle();

    // two frames; start+stop together, then a mid-stream start ignored
    new_test(1'b1);
    push_run(512, 24'h010000, 0);
    start_run(24'h010000, 16'd2, 2'd0, 1'b1);
    wait_beats(300);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_idle();

    // continuous, stop requested at beat 100 of frame 3
    new_test(1'b1);
    push_run(1024, 24'h028000, 1);
    start_run(24'h028000, 16'd0, 2'd1, 1'b0);
    wait_beats(3 * 256 + 100);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_idle();

    // attenuation by 4, then reset mid-frame
    new_test(1'b0);
    hand[64] = 8191;
    hand[192] = -8192;
    push_run(256, 24'h010000, 2);
    start_run(24'h010000, 16'd1, 2'd2, 1'b0);
    wait_beats(201);
    reset = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    q.delete();
    reset = 1'b1;
    repeat (2) tick();

    // restart after reset with an odd phase step
    new_test(1'b1);
    push_run(256, 24'h073A5C, 3);
    start_run(24'h073A5C, 16'd1, 2'd3, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
